// File: rtl/score_pkg.sv
// Shared constants and types for the Pong scoring block.
// Optional feature macro used by score_logic: SCORE_LOGIC_RALLY_EN.
package score_pkg;

  localparam int SCORE_W_DEF   = 4;
  localparam int WIN_SCORE_DEF = 10;
  localparam int RALLY_W       = 8;

  typedef logic [SCORE_W_DEF-1:0] score_t;

endpackage

// File: rtl/rise_detect.sv
// One-bit registered rising-edge detector. The input is sampled every
// cycle; rise is high while the input is 1 and the previous sample was 0,
// so the event is acted on by the clock edge that first samples it high.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev_q;

  // Remember the previous sample of the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= din;
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/score_logic.sv
// Point-scoring and match-end controller for Pong.
// A miss on one side scores a point for the other side. Scores saturate at
// WIN_SCORE, game_over is sticky until reset, and all events are ignored
// once the match is over. Simultaneous misses are treated as invalid.
// Optional feature macro: SCORE_LOGIC_RALLY_EN adds rally_count and
// longest_rally outputs driven by the paddle-hit events.
// WIN_SCORE must fit in SCORE_W bits.
module score_logic
  import score_pkg::*;
#(
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int WIN_SCORE = WIN_SCORE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hit_left,
  input  logic               hit_right,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over
`ifdef SCORE_LOGIC_RALLY_EN
  ,
  output logic [RALLY_W-1:0] rally_count,
  output logic [RALLY_W-1:0] longest_rally
`endif
);

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  logic hit_left_rise;
  logic hit_right_rise;
  logic miss_left_rise;
  logic miss_right_rise;

  logic [SCORE_W-1:0] score_left_d;
  logic [SCORE_W-1:0] score_right_d;
  logic               game_over_d;
  logic               point_scored;

  rise_detect u_hit_left (
    .clk   (clk),
    .reset (reset),
    .din   (hit_left),
    .rise  (hit_left_rise)
  );

  rise_detect u_hit_right (
    .clk   (clk),
    .reset (reset),
    .din   (hit_right),
    .rise  (hit_right_rise)
  );

  rise_detect u_miss_left (
    .clk   (clk),
    .reset (reset),
    .din   (miss_left),
    .rise  (miss_left_rise)
  );

  rise_detect u_miss_right (
    .clk   (clk),
    .reset (reset),
    .din   (miss_right),
    .rise  (miss_right_rise)
  );

  // Next-state scoring: one valid miss scores for the opposite side,
  // saturating at WIN; game_over latches when either score reaches WIN.
  always_comb begin
    score_left_d  = score_left;
    score_right_d = score_right;
    game_over_d   = game_over;
    point_scored  = 1'b0;
    if (!game_over) begin
      if (miss_left_rise && !miss_right_rise && (score_right != WIN)) begin
        score_right_d = score_right + SCORE_W'(1);
        point_scored  = 1'b1;
      end
      if (miss_right_rise && !miss_left_rise && (score_left != WIN)) begin
        score_left_d = score_left + SCORE_W'(1);
        point_scored = 1'b1;
      end
      game_over_d = (score_left_d == WIN) || (score_right_d == WIN);
    end
  end

  // Score and match-end registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_left  <= '0;
      score_right <= '0;
      game_over   <= 1'b0;
    end else begin
      score_left  <= score_left_d;
      score_right <= score_right_d;
      game_over   <= game_over_d;
    end
  end

`ifdef SCORE_LOGIC_RALLY_EN
  localparam logic [RALLY_W-1:0] RALLY_MAX = '1;

  logic [RALLY_W-1:0] rally_count_d;
  logic [RALLY_W-1:0] longest_rally_d;

  // Rally tracking: count hit edges (saturating), fold the rally into the
  // record and restart it whenever a point is scored; frozen after game over.
  always_comb begin
    rally_count_d   = rally_count;
    longest_rally_d = longest_rally;
    if (!game_over) begin
      if (point_scored) begin
        rally_count_d = '0;
        if (rally_count > longest_rally) longest_rally_d = rally_count;
      end else if ((hit_left_rise || hit_right_rise) && (rally_count != RALLY_MAX)) begin
        rally_count_d = rally_count + RALLY_W'(1);
      end
    end
  end

  // Rally registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rally_count   <= '0;
      longest_rally <= '0;
    end else begin
      rally_count   <= rally_count_d;
      longest_rally <= longest_rally_d;
    end
  end
`else
  // Hit edges have no consumer without the rally feature.
  logic unused_hits;
  assign unused_hits = hit_left_rise ^ hit_right_rise ^ point_scored;
`endif

endmodule

// File: tb/tb_score_logic.sv
// Directed testbench for score_logic. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the rising
// edge that updates them.
module tb_score_logic;
  import score_pkg::*;

  localparam int SW = SCORE_W_DEF;

  logic          clk;
  logic          reset;
  logic          hit_left;
  logic          hit_right;
  logic          miss_left;
  logic          miss_right;
  logic [SW-1:0] score_left;
  logic [SW-1:0] score_right;
  logic          game_over;
`ifdef SCORE_LOGIC_RALLY_EN
  logic [RALLY_W-1:0] rally_count;
  logic [RALLY_W-1:0] longest_rally;
`endif

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] exp_v;

  score_logic dut (
    .clk         (clk),
    .reset       (reset),
    .hit_left    (hit_left),
    .hit_right   (hit_right),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .score_left  (score_left),
    .score_right (score_right),
    .game_over   (game_over)
`ifdef SCORE_LOGIC_RALLY_EN
    ,
    .rally_count   (rally_count),
    .longest_rally (longest_rally)
`endif
  );

  // Clock: 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [SW-1:0] l,
                             input logic [SW-1:0] r, input logic g);
    check({tag, ".score_left"},  32'(score_left),  32'(l));
    check({tag, ".score_right"}, 32'(score_right), 32'(r));
    check({tag, ".game_over"},   32'(game_over),   32'(g));
  endtask

  // One-cycle pulse; returns at the falling edge after the updating edge.
  task automatic pulse_miss_left();
    @(negedge clk) miss_left = 1'b1;
    @(negedge clk) miss_left = 1'b0;
  endtask

  task automatic pulse_miss_right();
    @(negedge clk) miss_right = 1'b1;
    @(negedge clk) miss_right = 1'b0;
  endtask

  task automatic pulse_hit(input logic l, input logic r);
    @(negedge clk) begin hit_left = l; hit_right = r; end
    @(negedge clk) begin hit_left = 1'b0; hit_right = 1'b0; end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hit_left = 1'b0; hit_right = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_state("reset", 0, 0, 1'b0);
    reset = 1'b0;

    // Ten misses on the left: right side counts up to the winning score.
    for (int i = 1; i <= 10; i++) exp_q.push_back(SW'(i));
    for (int i = 1; i <= 10; i++) begin
      pulse_miss_left();
      exp_v = exp_q.pop_front();
      check_state($sformatf("run_right%0d", i), 0, exp_v, (i == 10));
    end

    // Match over: events ignored.
    pulse_miss_left();
    check_state("frozen_ml", 0, 10, 1'b1);
    pulse_miss_right();
    check_state("frozen_mr", 0, 10, 1'b1);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_state("async_reset", 0, 0, 1'b0);
    @(negedge clk) reset = 1'b0;
    pulse_miss_right();
    check_state("after_reset", 1, 0, 1'b0);

    // Level held five cycles counts once.
    @(negedge clk) miss_right = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_state($sformatf("held%0d", i), 2, 0, 1'b0);
    end
    miss_right = 1'b0;

    // Simultaneous misses are invalid.
    @(negedge clk) begin miss_left = 1'b1; miss_right = 1'b1; end
    @(negedge clk) begin miss_left = 1'b0; miss_right = 1'b0; end
    check_state("simul", 2, 0, 1'b0);
    pulse_miss_right();
    check_state("after_simul", 3, 0, 1'b0);

    // Hits never score.
    pulse_hit(1'b1, 1'b0);
    pulse_hit(1'b0, 1'b1);
    check_state("hits", 3, 0, 1'b0);

    // Left side reaches the winning score from 3.
    for (int i = 4; i <= 10; i++) begin
      pulse_miss_right();
      check_state($sformatf("run_left%0d", i), SW'(i), 0, (i == 10));
    end
    pulse_miss_right();
    check_state("sat_left", 10, 0, 1'b1);

    // Mid-match reset aborts and play resumes.
    do_reset();
    pulse_miss_left();
    pulse_miss_left();
    do_reset();
    check_state("abort", 0, 0, 1'b0);
    pulse_miss_left();
    check_state("resume", 0, 1, 1'b0);

`ifdef SCORE_LOGIC_RALLY_EN
    do_reset();
    check("rally_reset", 32'(rally_count), 0);
    pulse_hit(1'b1, 1'b0);
    check("rally1", 32'(rally_count), 1);
    pulse_hit(1'b0, 1'b1);
    check("rally2", 32'(rally_count), 2);
    pulse_hit(1'b1, 1'b1);
    check("rally3", 32'(rally_count), 3);
    pulse_miss_left();
    check("rally_clear", 32'(rally_count), 0);
    check("longest", 32'(longest_rally), 3);
    check_state("rally_point", 0, 1, 1'b0);
    pulse_hit(1'b1, 1'b0);
    pulse_miss_right();
    check("rally_clear2", 32'(rally_count), 0);
    check("longest_keep", 32'(longest_rally), 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
